posit_add_align: RTL and testbench
==================================

POSIT_ADD_ALIGN -- requirements
Module: posit_add_align

Interface
REQ-001 Parameter: MW, 32, mantissa width including hidden bit.
REQ-002 Parameter: SW, 10, signed scale width.
REQ-003 Parameter: S, 5, shift-amount width; 2**S SHALL equal MW.
REQ-004 Port: clk  in  1  single clock, rising edge.
REQ-005 Port: rst_n  in  1  asynchronous active-low reset.
REQ-006 Ports: in_valid  in  1 and in_ready  out  1; input handshake.
REQ-007 Ports: in_sa, in_sb  in  SW  signed scales of operands A and B.
REQ-008 Ports: in_ma, in_mb  in  MW  mantissas, MSB = hidden bit.
REQ-009 Ports: in_sign_a, in_sign_b, in_zero_a, in_zero_b, in_nar_a, in_nar_b  in  1 each  operand flags.
REQ-010 Ports: out_valid  out  1 and out_ready  in  1; output handshake.
REQ-011 Ports: out_scale  out  SW  scale of the larger operand.
REQ-012 Ports: out_ml, out_ms  out  MW  larger mantissa and aligned smaller mantissa.
REQ-013 Ports: out_sticky, out_sign_l, out_sub, out_zero, out_nar  out  1 each.

Function
REQ-014 Stage 1 SHALL register the larger operand selection: A is larger if in_zero_b, or (!in_zero_a and (sa>sb or (sa==sb and ma>=mb))); otherwise B.
REQ-015 Stage 1 SHALL compute diff = larger scale minus smaller scale in SW+1 bits, unsigned result.
REQ-016 Stage 2 SHALL right-shift the smaller mantissa by diff when diff<MW; when diff>=MW, out_ms SHALL be 0.
REQ-017 out_sticky SHALL be the OR of all mantissa bits shifted out; when diff>=MW it SHALL equal OR of the whole smaller mantissa.
REQ-018 out_sub SHALL equal sign_a XOR sign_b; out_sign_l SHALL be the sign of the larger operand.
REQ-019 out_zero SHALL be 1 only when both operands are zero; out_nar SHALL be in_nar_a OR in_nar_b. Other outputs are don't-care when out_nar=1.
REQ-020 Latency SHALL be exactly 2 cycles from input acceptance to out_valid without backpressure; throughput 1 per cycle.
REQ-021 Each stage SHALL advance when its register is empty or the downstream stage accepts: in_ready = !v1 | !v2 | out_ready.
REQ-022 While out_valid=1 and out_ready=0, all out_* SHALL hold stable; no transaction SHALL be dropped or duplicated.
REQ-023 Simultaneous accept at input and consume at output SHALL sustain full throughput with no bubble.
REQ-024 Transactions SHALL leave in acceptance order.

Reset
REQ-025 On rst_n=0 both stage valid bits, out_valid and all data registers SHALL clear to 0 asynchronously; in_ready SHALL be 1 during and after reset.
REQ-026 Reset asserted mid-operation SHALL discard all in-flight transactions; first transaction after release SHALL exit 2 cycles after acceptance.

Structure
REQ-027 MW, SW, S defaults and the stage-register struct fields SHALL live in the shared posit package.
REQ-028 The shift SHALL instantiate the team's existing dynamic right shifter DSR_right_N_S (N=MW, S=S); the sticky mask and saturation SHALL be local logic.

Verification
REQ-029 sa=3, ma=0x80000000, sb=1, mb=0xC0000001, out_ready=1 -> after 2 cycles out_scale=3, out_ml=0x80000000, out_ms=0x30000000, out_sticky=1.
REQ-030 sa=-5, sb=40, mb=0x80000000, ma=0xFFFFFFFF -> diff=45>=MW: out_ml=0x80000000, out_ms=0, out_sticky=1, out_sign_l=sign_b.
REQ-031 in_zero_a=1, sb=0, mb=0x90000000 -> out_ml=0x90000000, out_ms=0, out_sticky=0, out_zero=0; both zero -> out_zero=1.
REQ-032 10 back-to-back transactions, out_ready low for cycles 3-6 -> outputs stable while stalled, in_ready=0 once both stages full, all 10 delivered in order.
REQ-033 in_nar_a=1 -> out_nar=1 after 2 cycles; rst_n pulsed low with 2 transactions in flight -> out_valid=0 immediately, none emitted after release.

Source files
------------

// File: rtl/posit_add_align_pkg.sv
// Shared posit definitions: default widths, align-stage register layouts and operand ordering.
package posit_add_align_pkg;

  localparam int unsigned PositMw = 32;
  localparam int unsigned PositSw = 10;
  localparam int unsigned PositS  = 5;

  // Stage 1: operands ordered, scale difference computed, smaller mantissa not yet shifted.
  typedef struct packed {
    logic [PositSw-1:0] scale;
    logic [PositSw:0]   diff;
    logic [PositMw-1:0] ml;
    logic [PositMw-1:0] msm;
    logic               sign_l;
    logic               sub;
    logic               zero;
    logic               nar;
  } align_s1_t;

  // Stage 2: smaller mantissa aligned to the larger one.
  typedef struct packed {
    logic [PositSw-1:0] scale;
    logic [PositMw-1:0] ml;
    logic [PositMw-1:0] ms;
    logic               sticky;
    logic               sign_l;
    logic               sub;
    logic               zero;
    logic               nar;
  } align_s2_t;

  function automatic logic a_is_larger(logic [PositSw-1:0] sa, logic [PositSw-1:0] sb,
                                       logic [PositMw-1:0] ma, logic [PositMw-1:0] mb,
                                       logic za, logic zb);
    return zb || (!za && (($signed(sa) > $signed(sb)) || ((sa == sb) && (ma >= mb))));
  endfunction

  // Signed difference in one extra bit; never negative unless the smaller operand is zero.
  function automatic logic [PositSw:0] scale_diff(logic [PositSw-1:0] l, logic [PositSw-1:0] s);
    return {l[PositSw-1], l} - {s[PositSw-1], s};
  endfunction

endpackage

// File: rtl/posit_add_align_if.sv
// Input/output handshake bundle for the posit addition alignment pipeline.
interface posit_add_align_if
  import posit_add_align_pkg::*;
#(
  parameter int unsigned MW = PositMw,
  parameter int unsigned SW = PositSw
);
  logic          in_valid;
  logic          in_ready;
  logic [SW-1:0] in_sa;
  logic [SW-1:0] in_sb;
  logic [MW-1:0] in_ma;
  logic [MW-1:0] in_mb;
  logic          in_sign_a;
  logic          in_sign_b;
  logic          in_zero_a;
  logic          in_zero_b;
  logic          in_nar_a;
  logic          in_nar_b;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] out_scale;
  logic [MW-1:0] out_ml;
  logic [MW-1:0] out_ms;
  logic          out_sticky;
  logic          out_sign_l;
  logic          out_sub;
  logic          out_zero;
  logic          out_nar;

  modport master (
    output in_valid, in_sa, in_sb, in_ma, in_mb, in_sign_a, in_sign_b,
           in_zero_a, in_zero_b, in_nar_a, in_nar_b, out_ready,
    input  in_ready, out_valid, out_scale, out_ml, out_ms, out_sticky,
           out_sign_l, out_sub, out_zero, out_nar
  );

  modport slave (
    input  in_valid, in_sa, in_sb, in_ma, in_mb, in_sign_a, in_sign_b,
           in_zero_a, in_zero_b, in_nar_a, in_nar_b, out_ready,
    output in_ready, out_valid, out_scale, out_ml, out_ms, out_sticky,
           out_sign_l, out_sub, out_zero, out_nar
  );
endinterface

// File: rtl/DSR_right_N_S.sv
// Dynamic logical right shifter: c_o = a_i >> b_i, built as log2 mux stages.
module DSR_right_N_S #(
  parameter int unsigned N = 16,
  parameter int unsigned S = 4
) (
  input  logic [N-1:0] a_i,
  input  logic [S-1:0] b_i,
  output logic [N-1:0] c_o
);
  logic [N-1:0] stage [S+1];

  assign stage[0] = a_i;

  for (genvar i = 0; i < S; i++) begin : g_stage
    assign stage[i+1] = b_i[i] ? (stage[i] >> (2 ** i)) : stage[i];
  end

  assign c_o = stage[S];
endmodule

// File: rtl/posit_add_align.sv
// Two-stage posit addition alignment: order operands by magnitude, then shift the smaller
// mantissa right by the scale difference, collecting shifted-out bits into a sticky flag.
module posit_add_align
  import posit_add_align_pkg::*;
#(
  parameter int unsigned MW = PositMw,
  parameter int unsigned SW = PositSw,
  parameter int unsigned S  = PositS
) (
  input logic              clk,
  input logic              rst_n,
  posit_add_align_if.slave bus
);
  align_s1_t     s1_new, s1_d, s1_q;
  align_s2_t     s2_new, s2_d, s2_q;
  logic          v1_d, v1_q, v2_d, v2_q;
  logic          en1, en2, a_larger, zero_small;
  logic [S-1:0]  sh;
  logic          sat;
  logic [MW-1:0] shifted, out_mask;

  always_comb begin
    a_larger   = a_is_larger(bus.in_sa, bus.in_sb, bus.in_ma, bus.in_mb,
                             bus.in_zero_a, bus.in_zero_b);
    zero_small = a_larger ? bus.in_zero_b : bus.in_zero_a;
    s1_new        = '0;
    s1_new.scale  = a_larger ? bus.in_sa : bus.in_sb;
    s1_new.diff   = a_larger ? scale_diff(bus.in_sa, bus.in_sb) : scale_diff(bus.in_sb, bus.in_sa);
    s1_new.ml     = a_larger ? bus.in_ma : bus.in_mb;
    // A zero operand contributes nothing, whatever its mantissa field holds.
    s1_new.msm    = zero_small ? '0 : (a_larger ? bus.in_mb : bus.in_ma);
    s1_new.sign_l = a_larger ? bus.in_sign_a : bus.in_sign_b;
    s1_new.sub    = bus.in_sign_a ^ bus.in_sign_b;
    s1_new.zero   = bus.in_zero_a & bus.in_zero_b;
    s1_new.nar    = bus.in_nar_a | bus.in_nar_b;
  end

  assign sh       = s1_q.diff[S-1:0];
  // Any bit at or above 2**S means the shift reaches past the whole mantissa.
  assign sat      = |s1_q.diff[SW:S];
  assign out_mask = ~({MW{1'b1}} << sh);

  DSR_right_N_S #(
    .N(MW),
    .S(S)
  ) u_dsr (
    .a_i(s1_q.msm),
    .b_i(sh),
    .c_o(shifted)
  );

  always_comb begin
    s2_new        = '0;
    s2_new.scale  = s1_q.scale;
    s2_new.ml     = s1_q.ml;
    s2_new.ms     = sat ? '0 : shifted;
    s2_new.sticky = sat ? |s1_q.msm : |(s1_q.msm & out_mask);
    s2_new.sign_l = s1_q.sign_l;
    s2_new.sub    = s1_q.sub;
    s2_new.zero   = s1_q.zero;
    s2_new.nar    = s1_q.nar;
  end

  always_comb begin
    en2  = !v2_q || bus.out_ready;
    en1  = !v1_q || en2;
    v1_d = en1 ? bus.in_valid : v1_q;
    s1_d = (en1 && bus.in_valid) ? s1_new : s1_q;
    v2_d = en2 ? v1_q : v2_q;
    s2_d = (en2 && v1_q) ? s2_new : s2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign bus.in_ready   = en1;
  assign bus.out_valid  = v2_q;
  assign bus.out_scale  = s2_q.scale;
  assign bus.out_ml     = s2_q.ml;
  assign bus.out_ms     = s2_q.ms;
  assign bus.out_sticky = s2_q.sticky;
  assign bus.out_sign_l = s2_q.sign_l;
  assign bus.out_sub    = s2_q.sub;
  assign bus.out_zero   = s2_q.zero;
  assign bus.out_nar    = s2_q.nar;
endmodule

// File: tb/tb_posit_add_align.sv
// Bench for posit_add_align: vector table plus scoreboard, stall, latency and reset sequences.
module tb_posit_add_align;
  import posit_add_align_pkg::*;

  localparam int unsigned MW = PositMw;
  localparam int unsigned SW = PositSw;
  localparam int unsigned S  = PositS;

  typedef struct packed {
    logic [SW-1:0] sa;
    logic [SW-1:0] sb;
    logic [MW-1:0] ma;
    logic [MW-1:0] mb;
    logic sga, sgb, za, zb, na, nb;
  } in_t;

  typedef struct packed {
    logic [SW-1:0] scale;
    logic [MW-1:0] ml;
    logic [MW-1:0] ms;
    logic sticky, sign_l, sub, zero, nar;
  } exp_t;

  typedef struct packed {
    in_t  i;
    exp_t e;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb_q[$];
  exp_t held;
  logic stalled = 1'b0;
  vec_t tbl[10];

  always #5 clk = ~clk;

  posit_add_align_if #(.MW(MW), .SW(SW)) bus ();

  posit_add_align #(.MW(MW), .SW(SW), .S(S)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  function automatic in_t mk_in(logic [SW-1:0] sa, logic [SW-1:0] sb, logic [MW-1:0] ma,
                                logic [MW-1:0] mb, logic sga, logic sgb, logic za, logic zb,
                                logic na, logic nb);
    in_t v;
    v = '{sa: sa, sb: sb, ma: ma, mb: mb, sga: sga, sgb: sgb, za: za, zb: zb, na: na, nb: nb};
    return v;
  endfunction

  function automatic exp_t mk_exp(logic [SW-1:0] scale, logic [MW-1:0] ml, logic [MW-1:0] ms,
                                  logic sticky, logic sign_l, logic sub, logic zero, logic nar);
    exp_t e;
    e = '{scale: scale, ml: ml, ms: ms, sticky: sticky, sign_l: sign_l, sub: sub,
          zero: zero, nar: nar};
    return e;
  endfunction

  // Reference model written from integer arithmetic on the scales.
  function automatic exp_t model(in_t v);
    exp_t e;
    int sa, sb, d;
    logic a_l;
    logic [MW-1:0] msm;
    logic [63:0] lo;
    sa  = int'($signed(v.sa));
    sb  = int'($signed(v.sb));
    a_l = v.zb || (!v.za && (sa > sb || (sa == sb && v.ma >= v.mb)));
    e = '0;
    e.scale = a_l ? v.sa : v.sb;
    e.ml    = a_l ? v.ma : v.mb;
    msm     = a_l ? (v.zb ? '0 : v.mb) : (v.za ? '0 : v.ma);
    d       = a_l ? sa - sb : sb - sa;
    if (d < 0 || d >= int'(MW)) begin
      e.ms     = '0;
      e.sticky = (msm != '0);
    end else begin
      e.ms     = msm >> d;
      lo       = (64'd1 << d) - 64'd1;
      e.sticky = ((64'(msm) & lo) != 64'd0);
    end
    e.sign_l = a_l ? v.sga : v.sgb;
    e.sub    = v.sga ^ v.sgb;
    e.zero   = v.za & v.zb;
    e.nar    = v.na | v.nb;
    return e;
  endfunction

  function automatic exp_t cur_out();
    exp_t a;
    a = {bus.out_scale, bus.out_ml, bus.out_ms, bus.out_sticky, bus.out_sign_l,
         bus.out_sub, bus.out_zero, bus.out_nar};
    return a;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Output monitor: scoreboard pops on each handshake, hold check while stalled.
  always @(negedge clk) begin
    exp_t a, e;
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      a = cur_out();
      if (stalled) begin
        n_cmp++;
        if (a !== held) begin
          n_err++;
          $display("FAIL stall_hold: got %h, expected %h", a, held);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        n_cmp++;
        if (sb_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_output: got %h, expected no transaction", a);
        end else begin
          e = sb_q.pop_front();
          if (e.nar ? (a.nar !== 1'b1) : (a !== e)) begin
            n_err++;
            $display("FAIL out_data: got %h, expected %h", a, e);
          end
        end
      end
      stalled = bus.out_valid && !bus.out_ready;
      held    = a;
    end
  end

  task automatic set_in(in_t v);
    bus.in_sa     = v.sa;
    bus.in_sb     = v.sb;
    bus.in_ma     = v.ma;
    bus.in_mb     = v.mb;
    bus.in_sign_a = v.sga;
    bus.in_sign_b = v.sgb;
    bus.in_zero_a = v.za;
    bus.in_zero_b = v.zb;
    bus.in_nar_a  = v.na;
    bus.in_nar_b  = v.nb;
  endtask

  // Called at posedge+1; returns at posedge+1 after the transfer, leaving in_valid high.
  task automatic drive(in_t v, exp_t e);
    bit done = 1'b0;
    set_in(v);
    bus.in_valid = 1'b1;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        sb_q.push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL drive_timeout: in_ready got 0, expected 1");
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && sb_q.size() != 0; k++) @(posedge clk);
    #1;
    chk("drain_pending", 64'(sb_q.size()), 64'd0);
  endtask

  task automatic latency_check();
    in_t v;
    v = mk_in(10'd7, 10'd2, 32'hC000_0000, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    set_in(v);
    bus.in_valid = 1'b1;
    @(negedge clk);
    chk("lat_in_ready", 64'(bus.in_ready), 64'd1);
    if (bus.in_ready) sb_q.push_back(model(v));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("lat_cycle1_valid", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    chk("lat_cycle2_valid", 64'(bus.out_valid), 64'd1);
    drain();
  endtask

  function automatic in_t rand_in();
    in_t v;
    v.sa  = SW'($urandom_range(0, 80) - 40);
    v.sb  = SW'($urandom_range(0, 80) - 40);
    v.ma  = {1'b1, 31'($urandom)};
    v.mb  = {1'b1, 31'($urandom)};
    v.sga = 1'($urandom);
    v.sgb = 1'($urandom);
    v.za  = ($urandom_range(0, 9) == 0);
    v.zb  = ($urandom_range(0, 9) == 0);
    v.na  = 1'b0;
    v.nb  = 1'b0;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{mk_in(10'd3, 10'd1, 32'h8000_0000, 32'hC000_0001, 0, 0, 0, 0, 0, 0),
               mk_exp(10'd3, 32'h8000_0000, 32'h3000_0000, 1, 0, 0, 0, 0)};
    tbl[1] = '{mk_in(10'h3FB, 10'd40, 32'hFFFF_FFFF, 32'h8000_0000, 0, 1, 0, 0, 0, 0),
               mk_exp(10'd40, 32'h8000_0000, 32'h0, 1, 1, 1, 0, 0)};
    tbl[2] = '{mk_in(10'd0, 10'd0, 32'h0, 32'h9000_0000, 0, 0, 1, 0, 0, 0),
               mk_exp(10'd0, 32'h9000_0000, 32'h0, 0, 0, 0, 0, 0)};
    tbl[3] = '{mk_in(10'd0, 10'd0, 32'h0, 32'h0, 0, 0, 1, 1, 0, 0),
               mk_exp(10'd0, 32'h0, 32'h0, 0, 0, 0, 1, 0)};
    tbl[4] = '{mk_in(10'd2, 10'd2, 32'hA000_0000, 32'h8000_0000, 0, 0, 0, 0, 1, 0),
               mk_exp(10'd2, 32'hA000_0000, 32'h8000_0000, 0, 0, 0, 0, 1)};
    tbl[5] = '{mk_in(10'h3FD, 10'h3FD, 32'h8000_0001, 32'hF000_0000, 1, 0, 0, 0, 0, 0),
               mk_exp(10'h3FD, 32'hF000_0000, 32'h8000_0001, 0, 0, 1, 0, 0)};
    tbl[6] = '{mk_in(10'd31, 10'd0, 32'h8000_0000, 32'hC000_0000, 0, 0, 0, 0, 0, 0),
               mk_exp(10'd31, 32'h8000_0000, 32'h1, 1, 0, 0, 0, 0)};
    tbl[7] = '{mk_in(10'd32, 10'd0, 32'h8000_0000, 32'h8000_0000, 0, 0, 0, 0, 0, 0),
               mk_exp(10'd32, 32'h8000_0000, 32'h0, 1, 0, 0, 0, 0)};
    tbl[8] = '{mk_in(10'd5, 10'd5, 32'h8800_0000, 32'h8800_0000, 1, 1, 0, 0, 0, 0),
               mk_exp(10'd5, 32'h8800_0000, 32'h8800_0000, 0, 1, 0, 0, 0)};
    tbl[9] = '{mk_in(10'h3F6, 10'd100, 32'h9000_0000, 32'h0, 0, 1, 0, 1, 0, 0),
               mk_exp(10'h3F6, 32'h9000_0000, 32'h0, 0, 0, 1, 0, 0)};

    set_in('0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #2;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_ml", 64'(bus.out_ml), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

    for (int i = 0; i < 10; i++) drive(tbl[i].i, tbl[i].e);
    bus.in_valid = 1'b0;
    drain();

    for (int i = 0; i < 20; i++) begin
      in_t v;
      v = rand_in();
      drive(v, model(v));
    end
    bus.in_valid = 1'b0;
    drain();

    latency_check();

    // Ten back-to-back transfers with the output stalled for four cycles.
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          in_t v;
          v = rand_in();
          drive(v, model(v));
        end
        bus.in_valid = 1'b0;
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
        chk("stall_out_valid", 64'(bus.out_valid), 64'd1);
        repeat (4) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two transactions in flight.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) drive(rand_in(), model(tbl[0].i));
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("midrst_out_ml", 64'(bus.out_ml), 64'd0);
    sb_q.delete();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("post_midrst_valid", 64'(bus.out_valid), 64'd0);
    latency_check();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
